// File: rtl/mbist_mem_arbiter_if.sv
// Signal bundle between the SRAM arbiter, the host path, the MBIST controller and the SRAM.
// slave is the arbiter's view; master is the surrounding environment.
interface mbist_mem_arbiter_if #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 32
);
   logic                  bist_req;
   logic                  bist_grant;
   logic                  bist_start;
   logic                  bist_done;
   logic                  bist_fail;
   logic                  bist_cs;
   logic                  bist_we;
   logic                  bist_re;
   logic [ADDR_WIDTH-1:0] bist_addr;
   logic [DATA_WIDTH-1:0] bist_wdata;
   logic                  func_cs;
   logic                  func_we;
   logic                  func_re;
   logic [ADDR_WIDTH-1:0] func_addr;
   logic [DATA_WIDTH-1:0] func_wdata;
   logic                  func_ready;
   logic [DATA_WIDTH-1:0] func_rdata;
   logic                  func_rvalid;
   logic                  mem_cs;
   logic                  mem_we;
   logic                  mem_re;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [DATA_WIDTH-1:0] mem_wdata;
   logic [DATA_WIDTH-1:0] mem_rdata;
   logic                  result_valid;
   logic                  result_fail;
   logic                  result_timeout;

   modport slave (
      input  bist_req, bist_done, bist_fail, bist_cs, bist_we, bist_re, bist_addr, bist_wdata,
      input  func_cs, func_we, func_re, func_addr, func_wdata, mem_rdata,
      output bist_grant, bist_start, func_ready, func_rdata, func_rvalid,
      output mem_cs, mem_we, mem_re, mem_addr, mem_wdata,
      output result_valid, result_fail, result_timeout
   );

   modport master (
      output bist_req, bist_done, bist_fail, bist_cs, bist_we, bist_re, bist_addr, bist_wdata,
      output func_cs, func_we, func_re, func_addr, func_wdata, mem_rdata,
      input  bist_grant, bist_start, func_ready, func_rdata, func_rvalid,
      input  mem_cs, mem_we, mem_re, mem_addr, mem_wdata,
      input  result_valid, result_fail, result_timeout
   );
endinterface

// File: rtl/mbist_mem_arbiter.sv
// Shares the single SRAM port between the host path and the MBIST controller,
// draining host reads before handing over and latching the BIST result under a watchdog.
//
// state         | meaning
// ST_FUNC       | host owns the SRAM port
// ST_DRAIN      | host blocked, waiting for in-flight reads to return
// ST_BIST_START | one-cycle start pulse to the MBIST controller
// ST_BIST_RUN   | MBIST owns the port, watchdog counting
// ST_DONE       | result held, waiting for bist_req to drop
module mbist_mem_arbiter #(
   parameter int ADDR_WIDTH     = 8,
   parameter int DATA_WIDTH     = 32,
   parameter int READ_LATENCY   = 1,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input logic                clk,
   input logic                reset_n,
   mbist_mem_arbiter_if.slave bus
);
   localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam int DR_W = $clog2(READ_LATENCY + 1);
   localparam logic [WD_W-1:0] WD_LAST    = WD_W'(TIMEOUT_CYCLES - 1);
   localparam logic [DR_W-1:0] DRAIN_LOAD = DR_W'(READ_LATENCY);

   typedef enum logic [2:0] {
      ST_FUNC, ST_DRAIN, ST_BIST_START, ST_BIST_RUN, ST_DONE
   } state_t;

   state_t                  state, state_nxt;
   logic [DR_W-1:0]         drain_cnt, drain_cnt_nxt;
   logic [WD_W-1:0]         wd_cnt, wd_cnt_nxt;
   logic                    armed, armed_nxt;
   logic                    res_valid, res_valid_nxt;
   logic                    res_fail, res_fail_nxt;
   logic                    res_timeout, res_timeout_nxt;
   logic [READ_LATENCY-1:0] rv_pipe;
   logic                    func_ready;
   logic                    mem_cs_mux, mem_we_mux, mem_re_mux;
   logic [ADDR_WIDTH-1:0]   mem_addr_mux;
   logic [DATA_WIDTH-1:0]   mem_wdata_mux;

   assign func_ready = (state == ST_FUNC) && !bus.bist_req;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= ST_FUNC;
         drain_cnt   <= '0;
         wd_cnt      <= '0;
         armed       <= 1'b0;
         res_valid   <= 1'b0;
         res_fail    <= 1'b0;
         res_timeout <= 1'b0;
      end else begin
         state       <= state_nxt;
         drain_cnt   <= drain_cnt_nxt;
         wd_cnt      <= wd_cnt_nxt;
         armed       <= armed_nxt;
         res_valid   <= res_valid_nxt;
         res_fail    <= res_fail_nxt;
         res_timeout <= res_timeout_nxt;
      end
   end

   // armed records that bist_req was seen low in ST_FUNC, so a request held
   // high across DONE cannot start a second test.
   always_comb begin
      state_nxt       = state;
      drain_cnt_nxt   = drain_cnt;
      wd_cnt_nxt      = wd_cnt;
      armed_nxt       = armed;
      res_valid_nxt   = res_valid;
      res_fail_nxt    = res_fail;
      res_timeout_nxt = res_timeout;
      case (state)
         ST_FUNC: begin
            if (!bus.bist_req) begin
               armed_nxt = 1'b1;
            end else if (armed) begin
               state_nxt       = ST_DRAIN;
               armed_nxt       = 1'b0;
               drain_cnt_nxt   = DRAIN_LOAD;
               res_valid_nxt   = 1'b0;
               res_fail_nxt    = 1'b0;
               res_timeout_nxt = 1'b0;
            end
         end
         ST_DRAIN: begin
            drain_cnt_nxt = drain_cnt - DR_W'(1);
            if (!bus.bist_req) begin
               state_nxt = ST_FUNC;
            end else if (drain_cnt <= DR_W'(1)) begin
               state_nxt = ST_BIST_START;
            end
         end
         ST_BIST_START: begin
            state_nxt  = ST_BIST_RUN;
            wd_cnt_nxt = '0;
         end
         ST_BIST_RUN: begin
            // wd_cnt == 0 marks the first run cycle, where a stale done is ignored
            if (bus.bist_done && (wd_cnt != '0)) begin
               state_nxt       = ST_DONE;
               res_valid_nxt   = 1'b1;
               res_fail_nxt    = bus.bist_fail;
               res_timeout_nxt = 1'b0;
            end else if (wd_cnt == WD_LAST) begin
               state_nxt       = ST_DONE;
               res_valid_nxt   = 1'b1;
               res_fail_nxt    = 1'b1;
               res_timeout_nxt = 1'b1;
            end else begin
               wd_cnt_nxt = wd_cnt + WD_W'(1);
            end
         end
         ST_DONE: begin
            if (!bus.bist_req) state_nxt = ST_FUNC;
         end
         default: state_nxt = ST_FUNC;
      endcase
   end

   always_comb begin
      mem_cs_mux    = 1'b0;
      mem_we_mux    = 1'b0;
      mem_re_mux    = 1'b0;
      mem_addr_mux  = '0;
      mem_wdata_mux = '0;
      if (func_ready) begin
         mem_cs_mux    = bus.func_cs;
         mem_we_mux    = bus.func_we;
         mem_re_mux    = bus.func_re;
         mem_addr_mux  = bus.func_addr;
         mem_wdata_mux = bus.func_wdata;
      end else if (state == ST_BIST_RUN) begin
         mem_cs_mux    = bus.bist_cs;
         mem_we_mux    = bus.bist_we;
         mem_re_mux    = bus.bist_re;
         mem_addr_mux  = bus.bist_addr;
         mem_wdata_mux = bus.bist_wdata;
      end
   end

   // Keeps shifting in every state so reads accepted before DRAIN still complete.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rv_pipe <= '0;
      end else begin
         rv_pipe[0] <= bus.func_cs & bus.func_re & func_ready;
         for (int i = 1; i < READ_LATENCY; i++) rv_pipe[i] <= rv_pipe[i-1];
      end
   end

   assign bus.func_ready     = func_ready;
   assign bus.func_rvalid    = rv_pipe[READ_LATENCY-1];
   assign bus.func_rdata     = bus.mem_rdata;
   assign bus.mem_cs         = mem_cs_mux;
   assign bus.mem_we         = mem_we_mux;
   assign bus.mem_re         = mem_re_mux;
   assign bus.mem_addr       = mem_addr_mux;
   assign bus.mem_wdata      = mem_wdata_mux;
   assign bus.bist_start     = (state == ST_BIST_START);
   assign bus.bist_grant     = (state == ST_BIST_START) || (state == ST_BIST_RUN) || (state == ST_DONE);
   assign bus.result_valid   = res_valid;
   assign bus.result_fail    = res_fail;
   assign bus.result_timeout = res_timeout;
endmodule

// File: tb/tb_mbist_mem_arbiter.sv
// Bench for mbist_mem_arbiter: SRAM model with an optional stuck-at-0 bit, a small March-style
// controller driven from tasks, and a second instance with a short watchdog for timeout checks.
module tb_mbist_mem_arbiter;
   localparam int AW = 8;
   localparam int DW = 32;
   localparam int RL = 1;
   localparam logic [DW-1:0] P1 = 32'hFFFF_FFFF;

   logic clk = 1'b0;
   logic reset_n;
   always #5 clk = ~clk;

   mbist_mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
   mbist_mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_to ();

   mbist_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(RL), .TIMEOUT_CYCLES(1000000))
      dut (.clk(clk), .reset_n(reset_n), .bus(bus));
   mbist_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(RL), .TIMEOUT_CYCLES(50))
      dut_to (.clk(clk), .reset_n(reset_n), .bus(bus_to));

   logic [DW-1:0] sram [0:255];
   logic [DW-1:0] sram_rdata;
   bit            fault_en = 1'b0;

   always @(posedge clk) begin
      if (bus.mem_cs && bus.mem_we)
         sram[bus.mem_addr] <= (fault_en && bus.mem_addr == 8'd17) ? (bus.mem_wdata & ~32'h1) : bus.mem_wdata;
      if (bus.mem_cs && bus.mem_re) sram_rdata <= sram[bus.mem_addr];
   end
   assign bus.mem_rdata    = sram_rdata;
   assign bus_to.mem_rdata = '0;

   // reference model: expected memory contents, plain array
   logic [DW-1:0] exp_mem [0:255];
   bit            known   [0:255];
   int errors = 0;
   int checks = 0;

   typedef struct packed { logic v; logic [DW-1:0] d; } rd_t;

   function automatic logic [DW-1:0] p2(input int a);
      return 32'h5A5A_0000 | DW'(a);
   endfunction

   task automatic init_inputs();
      bus.bist_req = 0; bus.bist_done = 0; bus.bist_fail = 0;
      bus.bist_cs = 0; bus.bist_we = 0; bus.bist_re = 0; bus.bist_addr = '0; bus.bist_wdata = '0;
      bus.func_cs = 0; bus.func_we = 0; bus.func_re = 0; bus.func_addr = '0; bus.func_wdata = '0;
      bus_to.bist_req = 0; bus_to.bist_done = 0; bus_to.bist_fail = 0;
      bus_to.bist_cs = 0; bus_to.bist_we = 0; bus_to.bist_re = 0; bus_to.bist_addr = '0; bus_to.bist_wdata = '0;
      bus_to.func_cs = 0; bus_to.func_we = 0; bus_to.func_re = 0; bus_to.func_addr = '0; bus_to.func_wdata = '0;
   endtask

   task automatic host_idle();
      bus.func_cs = 0; bus.func_we = 0; bus.func_re = 0;
   endtask

   // one host read, expecting data d RL cycles later
   task automatic host_read_check(input int a, input logic [DW-1:0] d, input string name);
      @(negedge clk);
      bus.func_cs = 1; bus.func_we = 0; bus.func_re = 1; bus.func_addr = AW'(a);
      @(negedge clk);
      host_idle();
      repeat (RL - 1) @(negedge clk);
      checks++;
      if (bus.func_rvalid !== 1'b1 || bus.func_rdata !== d) begin
         errors++;
         $display("FAIL %s: rvalid=%b rdata=%h, required rvalid=1 rdata=%h", name, bus.func_rvalid, bus.func_rdata, d);
      end
   endtask

   task automatic start_bist(output int edges);
      bus.bist_req = 0;
      @(negedge clk);
      bus.bist_req = 1;
      edges = 0;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (bus.bist_start === 1'b1) begin edges = k; break; end
      end
   endtask

   task automatic test_reset();
      reset_n = 0;
      init_inputs();
      repeat (3) @(negedge clk);
      checks++;
      if ({bus.bist_grant, bus.bist_start, bus.func_rvalid, bus.mem_cs, bus.result_valid, bus.result_fail,
           bus.result_timeout} !== 7'b0) begin
         errors++;
         $display("FAIL reset_outputs: got %b, required 0000000", {bus.bist_grant, bus.bist_start,
                  bus.func_rvalid, bus.mem_cs, bus.result_valid, bus.result_fail, bus.result_timeout});
      end
      reset_n = 1;
      repeat (2) @(negedge clk);
      checks++;
      if (bus.func_ready !== 1'b1) begin
         errors++; $display("FAIL reset_func_ready: got %b, required 1", bus.func_ready);
      end
   endtask

   task automatic test_host_rw();
      @(negedge clk);
      bus.func_cs = 1; bus.func_we = 1; bus.func_re = 0; bus.func_addr = 8'd3; bus.func_wdata = 32'hA5A5_0001;
      exp_mem[3] = 32'hA5A5_0001; known[3] = 1;
      @(negedge clk);
      host_idle();
      checks++;
      if (bus.func_rvalid !== 1'b0) begin
         errors++; $display("FAIL write_no_rvalid: got %b, required 0", bus.func_rvalid);
      end
      host_read_check(3, 32'hA5A5_0001, "host_rw_addr3");
   endtask

   task automatic test_random_host();
      rd_t q[$];
      rd_t e;
      int  a, op;
      logic [DW-1:0] d;
      for (int i = 0; i < 80 + RL; i++) begin
         @(negedge clk);
         if (q.size() == RL) begin
            e = q.pop_front();
            checks++;
            if (bus.func_rvalid !== e.v || (e.v && bus.func_rdata !== e.d)) begin
               errors++;
               $display("FAIL random_host[%0d]: rvalid=%b rdata=%h, required rvalid=%b rdata=%h",
                        i, bus.func_rvalid, bus.func_rdata, e.v, e.d);
            end
         end
         if (i >= 80) begin
            host_idle(); q.push_back('{v: 1'b0, d: '0});
            continue;
         end
         op = int'($urandom_range(0, 2));
         a  = int'($urandom_range(0, 31));
         if (op == 0) begin
            host_idle(); q.push_back('{v: 1'b0, d: '0});
         end else if (op == 1 || !known[a]) begin
            d = $urandom;
            bus.func_cs = 1; bus.func_we = 1; bus.func_re = 0; bus.func_addr = AW'(a); bus.func_wdata = d;
            exp_mem[a] = d; known[a] = 1;
            q.push_back('{v: 1'b0, d: '0});
         end else begin
            bus.func_cs = 1; bus.func_we = 0; bus.func_re = 1; bus.func_addr = AW'(a);
            q.push_back('{v: 1'b1, d: exp_mem[a]});
         end
      end
      host_idle();
   endtask

   // Acts as the MBIST controller; expects to be called on the negedge where bist_start is high.
   task automatic run_march(input bit fault);
      int leaks = 0;
      bit fail = 0;
      @(negedge clk);
      bus.func_cs = 1; bus.func_we = 1; bus.func_re = 1; bus.func_addr = 8'd3; bus.func_wdata = 32'hDEAD_BEEF;
      for (int a = 0; a < 256; a++) begin
         bus.bist_cs = 1; bus.bist_we = 1; bus.bist_re = 0; bus.bist_addr = AW'(a); bus.bist_wdata = P1;
         #1;
         if (bus.mem_cs !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_addr !== AW'(a) || bus.mem_wdata !== P1) leaks++;
         @(negedge clk);
      end
      bus.bist_cs = 0; bus.bist_we = 0;
      #1;
      if (bus.mem_cs !== 1'b0 || bus.mem_we !== 1'b0) leaks++;
      @(negedge clk);
      for (int a = 0; a < 256; a++) begin
         bus.bist_cs = 1; bus.bist_we = 0; bus.bist_re = 1; bus.bist_addr = AW'(a);
         #1;
         if (bus.mem_cs !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_addr !== AW'(a)) leaks++;
         @(negedge clk);
         if (bus.func_rdata !== P1) fail = 1;
         bus.bist_we = 1; bus.bist_re = 0; bus.bist_wdata = p2(a);
         #1;
         if (bus.mem_we !== 1'b1 || bus.mem_wdata !== p2(a)) leaks++;
         @(negedge clk);
      end
      bus.bist_cs = 0; bus.bist_we = 0; bus.bist_re = 0;
      bus.bist_done = 1; bus.bist_fail = fail;
      @(negedge clk);
      bus.bist_done = 0; bus.bist_fail = 0;
      host_idle();
      checks++;
      if (leaks != 0) begin
         errors++; $display("FAIL march_port_mux: %0d bad cycles, required 0", leaks);
      end
      checks++;
      if ({bus.bist_grant, bus.result_valid, bus.result_fail, bus.result_timeout} !== {1'b1, 1'b1, fault, 1'b0}) begin
         errors++;
         $display("FAIL march_result(fault=%0d): grant/valid/fail/timeout=%b, required %b", fault,
                  {bus.bist_grant, bus.result_valid, bus.result_fail, bus.result_timeout}, {1'b1, 1'b1, fault, 1'b0});
      end
      for (int a = 0; a < 256; a++) begin
         exp_mem[a] = p2(a); known[a] = 1;
      end
      if (fault) exp_mem[17][0] = 1'b0;
   endtask

   task automatic test_drain_read_and_clean_march();
      int edges = 0;
      @(negedge clk);
      bus.func_cs = 1; bus.func_we = 0; bus.func_re = 1; bus.func_addr = 8'd3;
      @(negedge clk);
      checks++;
      if (bus.func_rvalid !== 1'b1 || bus.func_rdata !== exp_mem[3]) begin
         errors++;
         $display("FAIL pre_drain_read: rvalid=%b rdata=%h, required 1 %h", bus.func_rvalid, bus.func_rdata, exp_mem[3]);
      end
      bus.bist_req = 1; bus.func_addr = 8'd5;
      #1;
      checks++;
      if ({bus.func_ready, bus.mem_cs} !== 2'b00) begin
         errors++; $display("FAIL req_cycle_blocks_host: ready/mem_cs=%b, required 00", {bus.func_ready, bus.mem_cs});
      end
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (k == 1) begin
            host_idle();
            checks++;
            if (bus.func_rvalid !== 1'b0) begin
               errors++; $display("FAIL blocked_read_no_rvalid: got %b, required 0", bus.func_rvalid);
            end
         end
         if (bus.bist_start === 1'b1) begin edges = k; break; end
      end
      checks++;
      if (edges != RL + 1) begin
         errors++; $display("FAIL start_latency: %0d cycles, required %0d", edges, RL + 1);
      end
      run_march(1'b0);
   endtask

   task automatic test_done_hold();
      int starts = 0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         if (bus.bist_start !== 1'b0 || bus.bist_grant !== 1'b1 || bus.result_valid !== 1'b1) starts++;
      end
      checks++;
      if (starts != 0) begin
         errors++; $display("FAIL done_hold: %0d bad cycles, required 0", starts);
      end
      bus.bist_req = 0;
      @(negedge clk);
      checks++;
      if ({bus.bist_grant, bus.func_ready, bus.result_valid} !== 3'b011) begin
         errors++;
         $display("FAIL release_grant: grant/ready/valid=%b, required 011", {bus.bist_grant, bus.func_ready, bus.result_valid});
      end
      bus.bist_req = 1;
      starts = 0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (bus.bist_start !== 1'b0 || bus.bist_grant !== 1'b0) starts++;
      end
      checks++;
      if (starts != 0) begin
         errors++; $display("FAIL no_retrigger: %0d bad cycles, required 0", starts);
      end
      bus.bist_req = 0;
      host_read_check(3, p2(3), "post_march_addr3");
   endtask

   task automatic test_march_fault();
      int edges;
      fault_en = 1;
      start_bist(edges);
      checks++;
      if (edges != RL + 1) begin
         errors++; $display("FAIL fault_start_latency: %0d cycles, required %0d", edges, RL + 1);
      end
      run_march(1'b1);
      fault_en = 0;
      bus.bist_req = 0;
      @(negedge clk);
      host_read_check(17, exp_mem[17], "post_fault_addr17");
   endtask

   task automatic test_stale_done();
      int edges;
      int run_edges = 0;
      bus.bist_done = 1; bus.bist_fail = 1;
      start_bist(edges);
      checks++;
      if (bus.result_valid !== 1'b0) begin
         errors++; $display("FAIL result_cleared_on_drain: got %b, required 0", bus.result_valid);
      end
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         if (bus.result_valid === 1'b1) begin run_edges = k; break; end
      end
      checks++;
      // one edge into BIST_RUN, first run cycle ignores done, second accepts it
      if (run_edges != 3 || {bus.result_fail, bus.result_timeout} !== 2'b10) begin
         errors++;
         $display("FAIL stale_done: %0d cycles fail/timeout=%b, required 3 cycles 10", run_edges,
                  {bus.result_fail, bus.result_timeout});
      end
      bus.bist_done = 0; bus.bist_fail = 0; bus.bist_req = 0;
      @(negedge clk);
   endtask

   task automatic test_drain_abort();
      int bad = 0;
      bus.bist_req = 0;
      @(negedge clk);
      bus.bist_req = 1;
      @(negedge clk);
      checks++;
      if ({bus.bist_grant, bus.func_ready, bus.result_valid} !== 3'b000) begin
         errors++;
         $display("FAIL in_drain: grant/ready/valid=%b, required 000", {bus.bist_grant, bus.func_ready, bus.result_valid});
      end
      bus.bist_req = 0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (bus.bist_start !== 1'b0 || bus.bist_grant !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0 || bus.func_ready !== 1'b1) begin
         errors++; $display("FAIL drain_abort: %0d bad cycles ready=%b, required 0 cycles ready=1", bad, bus.func_ready);
      end
   endtask

   task automatic test_timeout();
      int st = 0;
      int run_edges = 0;
      bus_to.bist_req = 1;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (bus_to.bist_start === 1'b1) begin st = k; break; end
      end
      for (int k = 1; k <= 100; k++) begin
         @(negedge clk);
         if (bus_to.result_valid === 1'b1) begin run_edges = k; break; end
      end
      checks++;
      // one edge into BIST_RUN plus 50 watchdog cycles
      if (st != RL + 1 || run_edges != 51) begin
         errors++; $display("FAIL timeout_latency: start %0d run %0d, required %0d and 51", st, run_edges, RL + 1);
      end
      checks++;
      if ({bus_to.bist_grant, bus_to.result_fail, bus_to.result_timeout} !== 3'b111) begin
         errors++;
         $display("FAIL timeout_result: grant/fail/timeout=%b, required 111",
                  {bus_to.bist_grant, bus_to.result_fail, bus_to.result_timeout});
      end
      bus_to.bist_req = 0;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if ({bus_to.bist_grant, bus_to.func_ready} !== 2'b01) begin
         errors++; $display("FAIL timeout_release: grant/ready=%b, required 01", {bus_to.bist_grant, bus_to.func_ready});
      end
   endtask

   task automatic test_reset_mid_run();
      int edges;
      start_bist(edges);
      @(negedge clk);
      bus.bist_cs = 1; bus.bist_re = 1; bus.bist_addr = 8'd9;
      bus.bist_req = 0;
      repeat (3) @(negedge clk);
      checks++;
      if ({bus.bist_grant, bus.mem_cs} !== 2'b11) begin
         errors++; $display("FAIL run_ignores_req_drop: grant/mem_cs=%b, required 11", {bus.bist_grant, bus.mem_cs});
      end
      reset_n = 0;
      #1;
      checks++;
      if ({bus.bist_grant, bus.bist_start, bus.result_valid, bus.result_fail, bus.result_timeout,
           bus.mem_cs, bus.mem_re, bus.func_rvalid, bus.func_ready} !== 9'b000000001) begin
         errors++;
         $display("FAIL reset_mid_run: got %b, required 000000001", {bus.bist_grant, bus.bist_start,
                  bus.result_valid, bus.result_fail, bus.result_timeout, bus.mem_cs, bus.mem_re,
                  bus.func_rvalid, bus.func_ready});
      end
      @(negedge clk);
      reset_n = 1;
      bus.bist_cs = 0; bus.bist_re = 0;
      repeat (2) @(negedge clk);
      checks++;
      if ({bus.bist_grant, bus.func_ready} !== 2'b01) begin
         errors++; $display("FAIL after_reset: grant/ready=%b, required 01", {bus.bist_grant, bus.func_ready});
      end
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: bench did not finish");
      $fatal(1, "bench timeout");
   end

   initial begin
      for (int a = 0; a < 256; a++) begin exp_mem[a] = '0; known[a] = 0; end
      test_reset();
      test_host_rw();
      test_random_host();
      test_drain_read_and_clean_march();
      test_done_hold();
      test_march_fault();
      test_stale_done();
      test_drain_abort();
      test_timeout();
      test_reset_mid_run();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
